// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and global hold.
// Define ID_EX_PERF_COUNT_EN to add the perf_bubbles / perf_flushes event counters.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_reg_write,
  input  logic                  id_alu_src,
  input  logic                  id_mem_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_to_reg,
  input  logic                  id_branch,
  input  logic [1:0]            id_alu_op,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [XLEN-1:0]       id_pc,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_alu_src,
  output logic                  ex_mem_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_to_reg,
  output logic                  ex_branch,
  output logic [1:0]            ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [XLEN-1:0]       ex_pc,
  output logic                  hazard_stall
`ifdef ID_EX_PERF_COUNT_EN
  ,
  output logic [31:0]           perf_bubbles,
  output logic [31:0]           perf_flushes
`endif
);

  logic load_use;

  // A load in EX whose destination (other than x0) feeds the ID instruction.
  always_comb begin
    load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
               ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    hazard_stall = load_use & ~flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_pc         <= '0;
    end else if (flush || (!hold && load_use)) begin
      // Bubble: only valid and control are cleared; indices and data are left as-is.
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 2'b00;
    end else if (!hold) begin
      ex_valid      <= id_valid;
      ex_reg_write  <= id_reg_write  & id_valid;
      ex_alu_src    <= id_alu_src    & id_valid;
      ex_mem_write  <= id_mem_write  & id_valid;
      ex_mem_read   <= id_mem_read   & id_valid;
      ex_mem_to_reg <= id_mem_to_reg & id_valid;
      ex_branch     <= id_branch     & id_valid;
      ex_alu_op     <= id_alu_op & {2{id_valid}};
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_rs1_data   <= id_rs1_data;
      ex_rs2_data   <= id_rs2_data;
      ex_imm        <= id_imm;
      ex_pc         <= id_pc;
    end
  end

`ifdef ID_EX_PERF_COUNT_EN
  // Counters follow the same priority as the pipeline register; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubbles <= '0;
      perf_flushes <= '0;
    end else if (flush) begin
      perf_flushes <= perf_flushes + 32'd1;
    end else if (!hold && load_use) begin
      perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; perf counter checks are built when
// ID_EX_PERF_COUNT_EN is defined.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_reg_write, id_alu_src, id_mem_write, id_mem_read;
  logic        id_mem_to_reg, id_branch, id_uses_rs2;
  logic [1:0]  id_alu_op;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        flush, hold;
  logic        ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read;
  logic        ex_mem_to_reg, ex_branch;
  logic [1:0]  ex_alu_op;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic        hazard_stall;
`ifdef ID_EX_PERF_COUNT_EN
  logic [31:0] perf_bubbles, perf_flushes;
`endif

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_alu_src(id_alu_src),
    .id_mem_write(id_mem_write), .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .id_alu_op(id_alu_op), .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src),
    .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .ex_alu_op(ex_alu_op),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .hazard_stall(hazard_stall)
`ifdef ID_EX_PERF_COUNT_EN
    , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic asrc, input logic mw,
                       input logic mr, input logic m2r, input logic br, input logic [1:0] aop,
                       input logic u2, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [31:0] pc);
    id_valid = v; id_reg_write = rw; id_alu_src = asrc; id_mem_write = mw;
    id_mem_read = mr; id_mem_to_reg = m2r; id_branch = br; id_alu_op = aop;
    id_uses_rs2 = u2; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
    #1;
  endtask

  // lw rd, imm(rs1)
  task automatic drive_lw(input logic [4:0] rd, input logic [4:0] r1);
    drive(1, 1, 1, 0, 1, 1, 0, 2'b00, 0, r1, 5'd0, rd, 32'h100, 32'h0, 32'h4, 32'h40);
  endtask

  // add rd, rs1, rs2
  task automatic drive_add(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    drive(1, 1, 0, 0, 0, 0, 0, 2'b10, 1, r1, r2, rd, 32'h21, 32'h22, 32'h0, 32'h44);
  endtask

  task automatic test_reset();
    flush = 0; hold = 0; rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    checks++; if ({ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_branch, ex_alu_op} !== 9'd0) begin errors++; $display("[TB] FAIL reset_ctrl got %b exp 0", {ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_branch, ex_alu_op}); end
    checks++; if ({ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc} !== 143'd0) begin errors++; $display("[TB] FAIL reset_data got nonzero exp 0"); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b exp 0", hazard_stall); end
    rst = 0;
  endtask

  task automatic test_rtype();
    drive(1, 1, 0, 0, 0, 0, 0, 2'b10, 1, 5'd1, 5'd2, 5'd5, 32'h11, 32'h12, 32'h0, 32'h8);
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL rtype_stall_pre got %b exp 0", hazard_stall); end
    tick();
    checks++; if ({ex_valid, ex_reg_write, ex_alu_op} !== 4'b1110) begin errors++; $display("[TB] FAIL rtype_ctrl got %b exp 1110", {ex_valid, ex_reg_write, ex_alu_op}); end
    checks++; if (ex_rd !== 5'd5) begin errors++; $display("[TB] FAIL rtype_rd got %0d exp 5", ex_rd); end
    checks++; if (ex_rs1_data !== 32'h11) begin errors++; $display("[TB] FAIL rtype_rs1_data got %h exp 11", ex_rs1_data); end
    checks++; if (ex_pc !== 32'h8) begin errors++; $display("[TB] FAIL rtype_pc got %h exp 8", ex_pc); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL rtype_stall_post got %b exp 0", hazard_stall); end
  endtask

  task automatic test_load_use();
    drive_lw(5'd7, 5'd2);
    tick();
    checks++; if ({ex_valid, ex_mem_read, ex_rd} !== 7'b11_00111) begin errors++; $display("[TB] FAIL lu_lw_in_ex got %b exp 1100111", {ex_valid, ex_mem_read, ex_rd}); end
    drive_add(5'd8, 5'd3, 5'd7);
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall got %b exp 1", hazard_stall); end
    tick();
    checks++; if ({ex_valid, ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_to_reg, ex_alu_op} !== 7'd0) begin errors++; $display("[TB] FAIL lu_bubble_ctrl got %b exp 0", {ex_valid, ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_to_reg, ex_alu_op}); end
    checks++; if (ex_rd !== 5'd7 || ex_imm !== 32'h4) begin errors++; $display("[TB] FAIL lu_bubble_keep rd %0d imm %h exp 7 4", ex_rd, ex_imm); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_one_cycle got %b exp 0", hazard_stall); end
    tick();
    checks++; if ({ex_valid, ex_reg_write, ex_alu_op, ex_rd} !== 9'b1_1_10_01000) begin errors++; $display("[TB] FAIL lu_add_loads got %b exp 111001000", {ex_valid, ex_reg_write, ex_alu_op, ex_rd}); end
  endtask

  task automatic test_no_false_stall();
    drive_lw(5'd0, 5'd2);
    tick();
    drive_add(5'd9, 5'd0, 5'd4);
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL nfs_x0 got %b exp 0", hazard_stall); end
    drive_lw(5'd7, 5'd2);
    tick();
    // sw x7, 0(x3): rs2 not flagged as used
    drive(1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 5'd3, 5'd7, 5'd0, 32'h3, 32'h7, 32'h0, 32'h48);
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL nfs_uses_rs2 got %b exp 0", hazard_stall); end
    id_uses_rs2 = 1; #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL nfs_rs2_match got %b exp 1", hazard_stall); end
    id_valid = 0; #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL nfs_id_invalid got %b exp 0", hazard_stall); end
    tick();
  endtask

  task automatic test_flush();
    drive_lw(5'd7, 5'd2);
    tick();
    drive_add(5'd10, 5'd7, 5'd1);
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_stall got %b exp 1", hazard_stall); end
    flush = 1; #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall got %b exp 0", hazard_stall); end
    tick();
    checks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_rd} !== 8'b000_00111) begin errors++; $display("[TB] FAIL flush_bubble got %b exp 00000111", {ex_valid, ex_reg_write, ex_mem_read, ex_rd}); end
    flush = 0;
  endtask

  task automatic test_invalid_gating();
    drive(0, 1, 1, 1, 1, 1, 1, 2'b11, 1, 5'd12, 5'd13, 5'd14, 32'hC, 32'hD, 32'hE, 32'hF);
    tick();
    checks++; if ({ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_branch, ex_alu_op} !== 9'd0) begin errors++; $display("[TB] FAIL invalid_gated got %b exp 0", {ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_branch, ex_alu_op}); end
    checks++; if (ex_rd !== 5'd14 || ex_rs2_data !== 32'hD) begin errors++; $display("[TB] FAIL invalid_data rd %0d rs2_data %h exp 14 d", ex_rd, ex_rs2_data); end
  endtask

  task automatic test_hold();
    drive(1, 1, 0, 1, 0, 0, 1, 2'b01, 1, 5'd4, 5'd6, 5'd9, 32'hAA, 32'hBB, 32'hCC, 32'hDD);
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 0, 1, 0, 1, 1, 0, 2'b11, 0, 5'(i), 5'(i + 1), 5'(16 + i), 32'(i), 32'(i + 5), 32'h0, 32'(i * 4));
      tick();
      checks++; if ({ex_valid, ex_reg_write, ex_mem_write, ex_branch, ex_alu_op, ex_rd, ex_rs1_data, ex_pc} !== {6'b111101, 5'd9, 32'hAA, 32'hDD}) begin errors++; $display("[TB] FAIL hold_%0d got rd %0d d1 %h pc %h exp 9 aa dd", i, ex_rd, ex_rs1_data, ex_pc); end
    end
    hold = 0;
    drive(1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 5'd1, 5'd2, 5'd20, 32'h55, 32'h66, 32'h77, 32'h88);
    tick();
    checks++; if ({ex_valid, ex_alu_src, ex_rd, ex_rs1_data, ex_pc} !== {2'b11, 5'd20, 32'h55, 32'h88}) begin errors++; $display("[TB] FAIL hold_release got rd %0d d1 %h pc %h exp 20 55 88", ex_rd, ex_rs1_data, ex_pc); end
  endtask

  task automatic test_hold_with_load_use();
    drive_lw(5'd7, 5'd2);
    tick();
    drive_add(5'd11, 5'd7, 5'd0);
    hold = 1; #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL hold_lu_stall got %b exp 1", hazard_stall); end
    tick();
    checks++; if ({ex_valid, ex_mem_read, ex_rd} !== 7'b11_00111) begin errors++; $display("[TB] FAIL hold_lu_kept got %b exp 1100111", {ex_valid, ex_mem_read, ex_rd}); end
    hold = 0;
    tick();
    checks++; if ({ex_valid, ex_mem_read} !== 2'b00) begin errors++; $display("[TB] FAIL hold_lu_bubble got %b exp 00", {ex_valid, ex_mem_read}); end
    tick();
    checks++; if ({ex_valid, ex_rd} !== 6'b1_01011) begin errors++; $display("[TB] FAIL hold_lu_loads got %b exp 101011", {ex_valid, ex_rd}); end
  endtask

`ifdef ID_EX_PERF_COUNT_EN
  task automatic test_perf();
    rst = 1; tick(); rst = 0;
    checks++; if (perf_bubbles !== 32'd0 || perf_flushes !== 32'd0) begin errors++; $display("[TB] FAIL perf_reset got %0d %0d exp 0 0", perf_bubbles, perf_flushes); end
    drive_lw(5'd7, 5'd2); tick();
    drive_add(5'd8, 5'd7, 5'd0);
    hold = 1; tick(); hold = 0;
    tick(); tick();
    drive_lw(5'd7, 5'd2); tick();
    drive_add(5'd8, 5'd7, 5'd0); tick();
    flush = 1; tick(); tick();
    hold = 1; tick();
    flush = 0; tick(); hold = 0;
    checks++; if (perf_bubbles !== 32'd2) begin errors++; $display("[TB] FAIL perf_bubbles got %0d exp 2", perf_bubbles); end
    checks++; if (perf_flushes !== 32'd3) begin errors++; $display("[TB] FAIL perf_flushes got %0d exp 3", perf_flushes); end
    rst = 1; tick(); rst = 0;
    checks++; if (perf_bubbles !== 32'd0 || perf_flushes !== 32'd0) begin errors++; $display("[TB] FAIL perf_rst_clear got %0d %0d exp 0 0", perf_bubbles, perf_flushes); end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_invalid_gating();
    test_hold();
    test_hold_with_load_use();
`ifdef ID_EX_PERF_COUNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly downstream of the instruction-decode control unit.
- Registers the decoded control bundle (RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg, Branch, ALUOp) with operands, register indices, immediate and PC for the EX stage.
- Contains load-use hazard detection: inserts a bubble and stalls IF/ID and PC.
- Honours branch flush from EX and a global hold from the memory system.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_reg_write, id_alu_src, id_mem_write, id_mem_read, id_mem_to_reg, id_branch  in  1 each  control from the control unit
- id_alu_op  in  2  ALUOp from the control unit
- id_uses_rs2  in  1  instruction reads rs2 (R-type, store, branch)
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  register indices
- id_rs1_data, id_rs2_data, id_imm, id_pc  in  XLEN each  operands, immediate, PC
- flush  in  1  branch taken in EX; kill the ID instruction
- hold  in  1  global pipeline freeze
- ex_valid  out  1  EX holds a real instruction
- ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_branch  out  1 each  registered control
- ex_alu_op  out  2  registered ALUOp
- ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W each  registered indices
- ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  out  XLEN each  registered data
- hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle

Behaviour:
- Reset: all ex_* outputs are 0, including ex_valid, all control, indices and data.
- Reset is registered; hazard_stall evaluates to 0 while the registers are 0.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Load-use condition (combinational): lu = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2))).
- hazard_stall = lu & ~flush.
- Per-edge priority, highest first:
  1. rst: clear everything.
  2. flush: bubble.
  3. hold: all ex_* registers keep their value.
  4. lu: bubble.
  5. Otherwise load: all ex_* take the ID values; ex_valid = id_valid.
- Bubble: ex_valid and all control outputs (including ex_alu_op) go to 0. Indices and data fields keep their previous values.
- id_valid = 0 on a normal load: control fields are still loaded, but gated to 0 so an invalid slot never writes a register or memory.
- hold together with lu: hazard_stall is still asserted, and the registers hold.
- flush together with lu: flush wins; hazard_stall = 0.
- A bubble clears ex_mem_read, so a load-use stall lasts exactly 1 cycle (absent hold).
- rd = x0 never triggers a stall.

Optional Feature:
- Macro: ID_EX_PERF_COUNT_EN.
- Defined: adds outputs perf_bubbles (32-bit, counts load-use bubble cycles) and perf_flushes (32-bit, counts flush cycles).
  - Both counters clear on rst.
  - Neither counts while hold = 1 unless flush is also 1.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then R-type: rst 2 cycles then release; present id_valid = 1, reg_write = 1, alu_op = 2'b10, rd = 5, rs1_data = 0x11 → next edge ex_valid = 1, ex_reg_write = 1, ex_alu_op = 2'b10, ex_rd = 5, ex_rs1_data = 0x11; hazard_stall = 0 throughout.
- Load-use: lw with rd = 7 registered in EX; ID holds add with rs2 = 7, uses_rs2 = 1 → hazard_stall = 1 that cycle; next edge ex_valid = 0, all control 0, ex_rd still 7; following cycle hazard_stall = 0 and the add loads.
- No false stall:
  - lw rd = 0 in EX with ID rs1 = 0 → hazard_stall = 0.
  - lw rd = 7 with ID sw rs2 = 7 but uses_rs2 = 0 and rs1 = 3 → hazard_stall = 0.
- Flush priority: flush = 1 with a load-use condition present → hazard_stall = 0; next edge bubble (ex_valid = 0).
- Hold: hold = 1 for 3 cycles with changing ID inputs → ex_* unchanged for all 3 edges; release → latches the current ID values.
- Perf counters (ID_EX_PERF_COUNT_EN): 2 load-use bubbles plus 3 flushes, one of them with hold = 1 → perf_bubbles = 2, perf_flushes = 3; rst returns both to 0.
